// File: rtl/axi4_rch_drop_sender.sv
// R-channel error-burst injector: replays dropped read transactions as SLVERR
// bursts on the slave side and otherwise forwards master-side R traffic.
module axi4_rch_drop_sender #(
  parameter int C_AXI_ID_WIDTH    = 10,
  parameter int C_AXI_DATA_WIDTH  = 64,
  parameter int C_AXI_USER_WIDTH  = 4,
  parameter int C_DROP_FIFO_DEPTH = 4
) (
  input  logic                        axi4_aclk,
  input  logic                        axi4_arstn,

  input  logic [C_AXI_ID_WIDTH-1:0]   trans_id,
  input  logic [7:0]                  trans_len,
  input  logic                        trans_drop,
  output logic                        trans_drop_ready,

  output logic [C_AXI_ID_WIDTH-1:0]   s_axi4_rid,
  output logic [C_AXI_DATA_WIDTH-1:0] s_axi4_rdata,
  output logic [1:0]                  s_axi4_rresp,
  output logic                        s_axi4_rlast,
  output logic [C_AXI_USER_WIDTH-1:0] s_axi4_ruser,
  output logic                        s_axi4_rvalid,
  input  logic                        s_axi4_rready,

  input  logic [C_AXI_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi4_rdata,
  input  logic [1:0]                  m_axi4_rresp,
  input  logic                        m_axi4_rlast,
  input  logic [C_AXI_USER_WIDTH-1:0] m_axi4_ruser,
  input  logic                        m_axi4_rvalid,
  output logic                        m_axi4_rready
);

  localparam int PTR_W = (C_DROP_FIFO_DEPTH > 1) ? $clog2(C_DROP_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {PASS, DROP} state_t;

  state_t state, state_next;

  logic [C_AXI_ID_WIDTH-1:0] id_mem  [C_DROP_FIFO_DEPTH];
  logic [7:0]                len_mem [C_DROP_FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          count;
  logic [7:0]                beat_cnt;
  logic                      m_busy;

  logic push, pop, load_cnt, drop_hs;

  // Full-check uses registered count only, so a pop cannot free a slot for a
  // push in the same cycle.
  assign trans_drop_ready = (count < CNT_W'(C_DROP_FIFO_DEPTH));
  assign push             = trans_drop && trans_drop_ready;

  // NOTE: storage has no reset; every entry is written before it can be read,
  // and leaving it out keeps the array a plain RAM for synthesis.
  always_ff @(posedge axi4_aclk) begin
    if (push) begin
      id_mem[wr_ptr]  <= trans_id;
      len_mem[wr_ptr] <= trans_len;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Tracks an open master burst so injection never splits one.
  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      m_busy <= 1'b0;
    end else if (m_axi4_rvalid && m_axi4_rready) begin
      m_busy <= !m_axi4_rlast;
    end
  end

  assign drop_hs = (state == DROP) && s_axi4_rready;

  always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
    if (!axi4_arstn) begin
      state    <= PASS;
      beat_cnt <= '0;
    end else begin
      state <= state_next;
      if (load_cnt) begin
        beat_cnt <= len_mem[rd_ptr];
      end else if (drop_hs && beat_cnt != '0) begin
        beat_cnt <= beat_cnt - 8'd1;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next    = state;
    load_cnt      = 1'b0;
    pop           = 1'b0;
    s_axi4_rid    = m_axi4_rid;
    s_axi4_rdata  = m_axi4_rdata;
    s_axi4_rresp  = m_axi4_rresp;
    s_axi4_rlast  = m_axi4_rlast;
    s_axi4_ruser  = m_axi4_ruser;
    s_axi4_rvalid = m_axi4_rvalid;
    m_axi4_rready = s_axi4_rready;

    case (state)
      PASS: begin
        if (count != '0 && !m_axi4_rvalid && !m_busy) begin
          state_next = DROP;
          load_cnt   = 1'b1;
        end
      end
      DROP: begin
        s_axi4_rvalid = 1'b1;
        s_axi4_rid    = id_mem[rd_ptr];
        s_axi4_rdata  = '0;
        s_axi4_rresp  = 2'b10;
        s_axi4_ruser  = '0;
        s_axi4_rlast  = (beat_cnt == '0);
        m_axi4_rready = 1'b0;
        if (s_axi4_rready && beat_cnt == '0) begin
          pop        = 1'b1;
          state_next = PASS;
        end
      end
      default: state_next = PASS;
    endcase
  end

endmodule

// File: tb/tb_axi4_rch_drop_sender.sv
// Directed bench for axi4_rch_drop_sender: single drop, drop behind a master
// burst, backpressure, FIFO full, 256-beat burst and mid-drop reset.
module tb_axi4_rch_drop_sender;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  trans_id;
  logic [7:0]  trans_len;
  logic        trans_drop;
  logic        trans_drop_ready;
  logic [9:0]  s_rid;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [3:0]  s_ruser;
  logic        s_rvalid;
  logic        s_rready;
  logic [9:0]  m_rid;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [3:0]  m_ruser;
  logic        m_rvalid;
  logic        m_rready;

  int n_checks = 0;
  int n_fail   = 0;

  axi4_rch_drop_sender dut (
    .axi4_aclk        (clk),
    .axi4_arstn       (rst_n),
    .trans_id         (trans_id),
    .trans_len        (trans_len),
    .trans_drop       (trans_drop),
    .trans_drop_ready (trans_drop_ready),
    .s_axi4_rid       (s_rid),
    .s_axi4_rdata     (s_rdata),
    .s_axi4_rresp     (s_rresp),
    .s_axi4_rlast     (s_rlast),
    .s_axi4_ruser     (s_ruser),
    .s_axi4_rvalid    (s_rvalid),
    .s_axi4_rready    (s_rready),
    .m_axi4_rid       (m_rid),
    .m_axi4_rdata     (m_rdata),
    .m_axi4_rresp     (m_rresp),
    .m_axi4_rlast     (m_rlast),
    .m_axi4_ruser     (m_ruser),
    .m_axi4_rvalid    (m_rvalid),
    .m_axi4_rready    (m_rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on
  // the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_drop(input logic [9:0] id, input logic [7:0] len);
    trans_id   = id;
    trans_len  = len;
    trans_drop = 1'b1;
    tick();
    trans_drop = 1'b0;
  endtask

  task automatic drop_beat(input string tag, input logic [9:0] id, input logic last);
    check($sformatf("%s_rvalid", tag), s_rvalid, 1);
    check($sformatf("%s_rid",    tag), s_rid,    id);
    check($sformatf("%s_rresp",  tag), s_rresp,  2'b10);
    check($sformatf("%s_rdata",  tag), s_rdata,  0);
    check($sformatf("%s_ruser",  tag), s_ruser,  0);
    check($sformatf("%s_rlast",  tag), s_rlast,  last);
    check($sformatf("%s_mready", tag), m_rready, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [3:0] rdy_pat;

    rst_n = 1'b0; trans_id = '0; trans_len = '0; trans_drop = 1'b0;
    s_rready = 1'b1;
    m_rid = 10'h155; m_rdata = 64'h1234; m_rresp = 2'b01; m_rlast = 1'b1;
    m_ruser = 4'h9; m_rvalid = 1'b1;

    // Reset: passthrough of an active master beat, FIFO ready.
    smp();
    check("rst_rvalid", s_rvalid, 1);
    check("rst_rid",    s_rid,    10'h155);
    check("rst_rdata",  s_rdata,  64'h1234);
    check("rst_rresp",  s_rresp,  2'b01);
    check("rst_ready",  trans_drop_ready, 1);
    check("rst_mready", m_rready, 1);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    smp();
    check("rst_idle_rvalid", s_rvalid, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Test 1: single drop on idle master.
    push_drop(10'h2A, 8'd3);
    smp(); check("t1_gap_rvalid", s_rvalid, 0); tick();
    for (int b = 0; b < 4; b++) begin
      smp(); drop_beat($sformatf("t1_b%0d", b), 10'h2A, b == 3); tick();
    end
    smp();
    check("t1_done_rvalid", s_rvalid, 0);
    check("t1_done_mready", m_rready, 1);
    tick();

    // Test 2: drop pushed during beat 3 of an 8-beat master burst.
    for (int k = 1; k <= 8; k++) begin
      m_rvalid = 1'b1; m_rid = 10'h155; m_rdata = 64'hA5A5_0000_0000_0000 | 64'(k);
      m_rresp = 2'b01; m_ruser = 4'h9; m_rlast = (k == 8);
      if (k == 3) begin
        trans_id = 10'h3C; trans_len = 8'd1; trans_drop = 1'b1;
      end else begin
        trans_drop = 1'b0;
      end
      smp();
      check($sformatf("t2_m%0d_rvalid", k), s_rvalid, 1);
      check($sformatf("t2_m%0d_rid",    k), s_rid,    10'h155);
      check($sformatf("t2_m%0d_rdata",  k), s_rdata,  64'hA5A5_0000_0000_0000 | 64'(k));
      check($sformatf("t2_m%0d_rresp",  k), s_rresp,  2'b01);
      check($sformatf("t2_m%0d_rlast",  k), s_rlast,  k == 8);
      check($sformatf("t2_m%0d_mready", k), m_rready, 1);
      tick();
    end
    trans_drop = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
    smp(); check("t2_gap_rvalid", s_rvalid, 0); tick();
    smp(); drop_beat("t2_d0", 10'h3C, 1'b0); tick();
    // A master beat arriving mid-drop must be stalled.
    m_rvalid = 1'b1; m_rid = 10'h0F1; m_rdata = 64'h77; m_rlast = 1'b1;
    smp(); drop_beat("t2_d1", 10'h3C, 1'b1); tick();
    smp();
    check("t2_stalled_rvalid", s_rvalid, 1);
    check("t2_stalled_rid",    s_rid,    10'h0F1);
    check("t2_stalled_rdata",  s_rdata,  64'h77);
    check("t2_stalled_mready", m_rready, 1);
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;

    // Test 3: backpressure on a 2-beat drop.
    push_drop(10'h11, 8'd1);
    smp(); check("t3_gap_rvalid", s_rvalid, 0); tick();
    rdy_pat = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      s_rready = rdy_pat[3-i];
      smp(); drop_beat($sformatf("t3_c%0d", i), 10'h11, i != 0); tick();
    end
    s_rready = 1'b1;
    smp(); check("t3_done_rvalid", s_rvalid, 0); tick();

    // Test 4: fill the FIFO while a master burst is open.
    m_rvalid = 1'b1; m_rid = 10'h1F0; m_rlast = 1'b0;
    smp(); check("t4_m_first", s_rvalid, 1); tick();
    m_rvalid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      trans_id = 10'(i); trans_len = 8'd0; trans_drop = 1'b1;
      smp(); check($sformatf("t4_push%0d_ready", i), trans_drop_ready, 1); tick();
    end
    trans_id = 10'd5; trans_drop = 1'b1;
    smp(); check("t4_full_ready", trans_drop_ready, 0); tick();
    trans_drop = 1'b0;
    smp(); check("t4_held_rvalid", s_rvalid, 0); tick();
    m_rvalid = 1'b1; m_rlast = 1'b1;
    smp(); check("t4_m_last_rlast", s_rlast, 1); tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    for (int j = 0; j <= 10; j++) begin
      smp();
      if (j % 2 == 1 && j <= 7) begin
        drop_beat($sformatf("t4_j%0d", j), 10'((j + 1) / 2), 1'b1);
      end else begin
        check($sformatf("t4_j%0d_rvalid", j), s_rvalid, 0);
      end
      if (j == 2) check("t4_ready_after_pop", trans_drop_ready, 1);
      tick();
    end

    // Test 5: 256-beat drop.
    push_drop(10'h200, 8'd255);
    smp(); check("t5_gap_rvalid", s_rvalid, 0); tick();
    for (int b = 0; b < 256; b++) begin
      smp();
      check($sformatf("t5_b%0d_rvalid", b), s_rvalid, 1);
      check($sformatf("t5_b%0d_rlast",  b), s_rlast,  b == 255);
      check($sformatf("t5_b%0d_rid",    b), s_rid,    10'h200);
      tick();
    end
    smp(); check("t5_done_rvalid", s_rvalid, 0); tick();

    // Test 6: reset during beat 2 of a 6-beat drop with another drop queued.
    push_drop(10'h07, 8'd5);
    push_drop(10'h08, 8'd0);
    smp(); drop_beat("t6_b0", 10'h07, 1'b0); tick();
    rst_n = 1'b0;
    m_rvalid = 1'b1; m_rid = 10'h123; m_rresp = 2'b00; m_rdata = 64'h55; m_rlast = 1'b0;
    s_rready = 1'b0;
    smp();
    check("t6_rst_rvalid", s_rvalid, 1);
    check("t6_rst_rid",    s_rid,    10'h123);
    check("t6_rst_rresp",  s_rresp,  2'b00);
    check("t6_rst_rdata",  s_rdata,  64'h55);
    check("t6_rst_mready", m_rready, 0);
    check("t6_rst_ready",  trans_drop_ready, 1);
    tick();
    rst_n = 1'b1; m_rvalid = 1'b0; s_rready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      smp();
      check($sformatf("t6_post%0d_rvalid", i), s_rvalid, 0);
      check($sformatf("t6_post%0d_ready",  i), trans_drop_ready, 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_rch_drop_sender.md
Name: axi4_rch_drop_sender

Overview:
- Read-data-channel counterpart of the write-response drop path in the RAB slave port.
- When the RAB drops a read transaction (miss or protection fault), this block generates the full error burst on the slave-side R channel: len+1 beats, each with RRESP=SLVERR, zero data and user, and RLAST on the final beat.
- Between dropped bursts, it passes master-side R traffic through unchanged.
- It injects only between master bursts, so R bursts are never interleaved mid-stream.

Parameters:
- C_AXI_ID_WIDTH, 10, width of ID fields.
- C_AXI_DATA_WIDTH, 64, width of RDATA.
- C_AXI_USER_WIDTH, 4, width of RUSER.
- C_DROP_FIFO_DEPTH, 4, number of pending dropped transactions; power of two, ≥2.

Ports:
- axi4_aclk  in  1  clock.
- axi4_arstn  in  1  asynchronous active-low reset.
- trans_id  in  C_AXI_ID_WIDTH  ARID of the dropped read.
- trans_len  in  8  ARLEN of the dropped read (beats-1).
- trans_drop  in  1  push request for a dropped read.
- trans_drop_ready  out  1  drop FIFO not full.
- s_axi4_rid  out  C_AXI_ID_WIDTH  slave-side RID.
- s_axi4_rdata  out  C_AXI_DATA_WIDTH  slave-side RDATA.
- s_axi4_rresp  out  2  slave-side RRESP.
- s_axi4_rlast  out  1  slave-side RLAST.
- s_axi4_ruser  out  C_AXI_USER_WIDTH  slave-side RUSER.
- s_axi4_rvalid  out  1  slave-side RVALID.
- s_axi4_rready  in  1  slave-side RREADY.
- m_axi4_rid, m_axi4_rdata, m_axi4_rresp, m_axi4_rlast, m_axi4_ruser, m_axi4_rvalid  in  (matching widths)  master-side R channel.
- m_axi4_rready  out  1  master-side RREADY.

Behaviour:
- Drop FIFO:
  - Entries are {id, len}.
  - A push is accepted when trans_drop && trans_drop_ready.
  - trans_drop_ready = count < C_DROP_FIFO_DEPTH, derived from registered count only. When the FIFO is full, a push is refused even if a pop occurs in the same cycle.
  - Pointers wrap modulo depth.
  - A simultaneous push and pop on a non-full FIFO leaves count unchanged.
- Master burst tracking:
  - m_busy is set on an m_axi4_rvalid && m_axi4_rready beat with ~m_axi4_rlast.
  - m_busy is cleared on a handshake with m_axi4_rlast.
- State machine, PASS / DROP:
  - PASS -> DROP when FIFO non-empty && ~m_axi4_rvalid && ~m_busy. On entry, beat_cnt loads head.len.
  - In DROP, each s_axi4_rvalid && s_axi4_rready handshake decrements beat_cnt.
  - On the handshake where beat_cnt==0: pop the FIFO and return to PASS.
  - The earliest re-entry to DROP is the next cycle, so back-to-back dropped bursts have a 1-cycle gap.
- Outputs in PASS:
  - All s_* signals are the corresponding m_* signals.
  - m_axi4_rready = s_axi4_rready.
- Outputs in DROP:
  - s_axi4_rvalid = 1, s_axi4_rid = head.id, s_axi4_rdata = 0, s_axi4_rresp = 2'b10, s_axi4_ruser = 0.
  - s_axi4_rlast = (beat_cnt==0).
  - m_axi4_rready = 0, which stalls any master beat that arrives mid-drop.
- Latency:
  - A push accepted in cycle N is visible in the FIFO in N+1.
  - The state becomes DROP at the end of N+1 if the PASS->DROP conditions hold.
  - s_axi4_rvalid is first asserted by the block in N+2.
- trans_len=255 yields 256 beats; beat_cnt is 8 bits.
- Once asserted, s_axi4_rvalid is held in DROP until the handshake; outputs are stable while not ready.
- Reset, asynchronous:
  - FIFO empty, count 0, state PASS, m_busy 0, beat_cnt 0.
  - trans_drop_ready=1.
  - Outputs are passthrough of m_*, so s_axi4_rvalid follows m_axi4_rvalid (0 when the master is idle).
  - Reset mid-burst abandons the burst and all queued drops.

Test Plan:
- Single drop, idle master, id=0x2A, len=3, rready=1 -> s_rvalid high for 4 consecutive cycles starting 2 cycles after the push; rid=0x2A, rresp=2'b10, rdata=0; rlast on beat 4 only; m_rready=0 throughout.
- Drop pushed while master burst len=7 is on beat 3 -> master beats 3..8 pass unchanged; dropped burst starts only after the master RLAST handshake; no interleave.
- Backpressure: len=1, s_rready toggling 1,0,0,1 -> exactly 2 handshakes; rid/rresp/rlast stable during stall; state returns to PASS after the second handshake.
- Fill FIFO with 4 drops (ids 1..4, len 0) while master busy -> trans_drop_ready=0 after the 4th push; a 5th push is refused. After the master completes: single-beat bursts ids 1,2,3,4 in order, each with rlast=1, 1-cycle gaps.
- len=255 drop -> exactly 256 beats, rlast only on the 256th.
- Assert axi4_arstn low mid-drop (beat 2 of len 5) -> next cycle trans_drop_ready=1, outputs mirror m_*, no further injected beats.
